// File: rtl/cmd_decode_ctrl_if.sv
// Command, lookup, sensor-configuration and response signals of cmd_decode_ctrl.
// master: command parser / LUT / response consumer side; slave: the decoder.
interface cmd_decode_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 4
);
    logic [15:0]              op_code_bus;
    logic [DATA_W-1:0]        user_data_bus;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     lut_req;
    logic [7:0]               lut_addr;
    logic                     lut_ack;
    logic [DATA_W-1:0]        lut_data;
    logic [NUM_CH*DATA_W-1:0] sens_cfg;
    logic [NUM_CH-1:0]        sens_start;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_data;
    logic [1:0]               rsp_status;
    logic                     busy;

    modport master (
        output op_code_bus, user_data_bus, cmd_valid, lut_ack, lut_data, rsp_ready,
        input  cmd_ready, lut_req, lut_addr, sens_cfg, sens_start,
               rsp_valid, rsp_data, rsp_status, busy
    );

    modport slave (
        input  op_code_bus, user_data_bus, cmd_valid, lut_ack, lut_data, rsp_ready,
        output cmd_ready, lut_req, lut_addr, sens_cfg, sens_start,
               rsp_valid, rsp_data, rsp_status, busy
    );
endinterface

// File: rtl/cmd_decode_ctrl.sv
// Command decoder and sensor-configuration controller: buffers opcode/data words
// in a FIFO, executes them against per-channel configuration registers (with an
// optional LUT fetch) and returns one status/response per command.
module cmd_decode_ctrl #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       DEPTH       = 4,
    parameter int unsigned       TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] DEFAULT_CFG = '0
) (
    input  logic             clock,
    input  logic             reset_n,   // active-high asynchronous reset
    cmd_decode_ctrl_if.slave bus
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = 9;

    localparam logic [3:0] OP_LOOKUP  = 4'h1;
    localparam logic [3:0] OP_CONFIG  = 4'h2;
    localparam logic [3:0] OP_DEFAULT = 4'h3;
    localparam logic [3:0] OP_READ    = 4'h4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD_OP  = 2'b01;
    localparam logic [1:0] ST_BAD_CH  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef struct packed {
        logic [15:0]       op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, LOOKUP, RESP} state_t;

    // FIFO storage and bookkeeping
    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             nempty_q;
    logic             cmd_ready_q;
    logic             push, pop;

    // Controller state and registered outputs
    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [DATA_W-1:0]  cfg_q [NUM_CH];
    logic [DATA_W-1:0]  cfg_d [NUM_CH];
    logic [NUM_CH-1:0]  start_q, start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_status_q, rsp_status_d;
    logic               lut_req_q, lut_req_d;
    logic [7:0]         lut_addr_q, lut_addr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               busy_q, busy_d;

    logic [3:0]         cmd_opc, cmd_ch;
    logic               ch_ok;
    logic [DATA_W-1:0]  cfg_sel;

    assign push    = bus.cmd_valid && cmd_ready_q;
    assign pop     = (state_q == IDLE) && nempty_q;
    assign cmd_opc = cmd_q.op[15:12];
    assign cmd_ch  = cmd_q.op[11:8];
    assign ch_ok   = (cmd_ch < 4'(NUM_CH));

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO data array (no reset needed on storage)
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= '{op: bus.op_code_bus, data: bus.user_data_bus};
        end
    end

    // FIFO pointers, count and registered flags; non-empty flag lags count by a cycle
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            nempty_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            nempty_q    <= (count_q != '0);
            cmd_ready_q <= (count_d < CNT_W'(DEPTH));
        end
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cfg_d        = cfg_q;
        start_d      = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        lut_req_d    = lut_req_q;
        lut_addr_d   = lut_addr_q;
        wait_d       = wait_q;
        cfg_sel      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cmd_ch == 4'(c)) cfg_sel = cfg_q[c];
        end

        case (state_q)
            IDLE: begin
                if (nempty_q) begin
                    cmd_d   = mem[rd_ptr_q];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_status_d = ST_OK;
                rsp_data_d   = '0;
                case (cmd_opc)
                    OP_LOOKUP: begin
                        if (ch_ok) begin
                            state_d     = LOOKUP;
                            rsp_valid_d = 1'b0;
                            lut_req_d   = 1'b1;
                            lut_addr_d  = cmd_q.op[7:0];
                            wait_d      = '0;
                        end else begin
                            rsp_status_d = ST_BAD_CH;
                        end
                    end
                    OP_CONFIG: begin
                        if (ch_ok) begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (cmd_ch == 4'(c)) begin
                                    cfg_d[c]   = cmd_q.data;
                                    start_d[c] = 1'b1;
                                end
                            end
                            rsp_data_d = cmd_q.data;
                        end else begin
                            rsp_status_d = ST_BAD_CH;
                        end
                    end
                    OP_DEFAULT: begin
                        rsp_data_d = DEFAULT_CFG;
                        if (ch_ok) begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (cmd_ch == 4'(c)) begin
                                    cfg_d[c]   = DEFAULT_CFG;
                                    start_d[c] = 1'b1;
                                end
                            end
                        end else if (cmd_ch == 4'hF) begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                cfg_d[c] = DEFAULT_CFG;
                            end
                            start_d = '1;
                        end else begin
                            rsp_status_d = ST_BAD_CH;
                        end
                    end
                    OP_READ: begin
                        if (ch_ok) begin
                            rsp_data_d = cfg_sel;
                        end else begin
                            rsp_status_d = ST_BAD_CH;
                        end
                    end
                    default: rsp_status_d = ST_BAD_OP;
                endcase
            end
            LOOKUP: begin
                // ack takes priority over a timeout in the same cycle
                if (bus.lut_ack) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cmd_ch == 4'(c)) begin
                            cfg_d[c]   = bus.lut_data;
                            start_d[c] = 1'b1;
                        end
                    end
                    state_d      = RESP;
                    lut_req_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = bus.lut_data;
                    rsp_status_d = ST_OK;
                end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                    state_d      = RESP;
                    lut_req_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = '0;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cfg_q[c] <= DEFAULT_CFG;
            end
            start_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            lut_req_q    <= 1'b0;
            lut_addr_q   <= '0;
            wait_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cfg_q        <= cfg_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            lut_req_q    <= lut_req_d;
            lut_addr_q   <= lut_addr_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.lut_req    = lut_req_q;
    assign bus.lut_addr   = lut_addr_q;
    assign bus.sens_start = start_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.busy       = busy_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cfg
        assign bus.sens_cfg[c*DATA_W +: DATA_W] = cfg_q[c];
    end
endmodule

// File: tb/tb_cmd_decode_ctrl.sv
// Directed plus randomized bench for cmd_decode_ctrl with a spec-level model of
// the configuration registers and expected responses.
module tb_cmd_decode_ctrl;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [15:0] DEFAULT_CFG = 16'h0000;

    logic clock = 1'b0;
    logic reset_n;

    cmd_decode_ctrl_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    cmd_decode_ctrl #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT), .DEFAULT_CFG(DEFAULT_CFG)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_cfg [NUM_CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] flat_cfg();
        logic [63:0] f;
        f = '0;
        for (int c = 0; c < NUM_CH; c++) f[c*DATA_W +: DATA_W] = m_cfg[c];
        return f;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) m_cfg[c] = DEFAULT_CFG;
    endtask

    // Expected outcome of one command, applied to the model registers
    task automatic model_exec(input logic [15:0] op, input logic [15:0] d, input bit acked,
                              input logic [15:0] ld, output logic [1:0] st,
                              output logic [15:0] rd, output logic [3:0] sm);
        int opc, ch;
        bit in_rng;
        opc = int'(op[15:12]);
        ch  = int'(op[11:8]);
        in_rng = (ch < NUM_CH);
        st = 2'b00; rd = 16'h0; sm = 4'h0;
        if (opc == 1) begin
            if (!in_rng) st = 2'b10;
            else if (acked) begin m_cfg[ch] = ld; sm[ch] = 1'b1; rd = ld; end
            else st = 2'b11;
        end else if (opc == 2) begin
            if (!in_rng) st = 2'b10;
            else begin m_cfg[ch] = d; sm[ch] = 1'b1; rd = d; end
        end else if (opc == 3) begin
            rd = DEFAULT_CFG;
            if (in_rng) begin m_cfg[ch] = DEFAULT_CFG; sm[ch] = 1'b1; end
            else if (ch == 15) begin model_reset(); sm = 4'hF; end
            else st = 2'b10;
        end else if (opc == 4) begin
            if (!in_rng) st = 2'b10;
            else rd = m_cfg[ch];
        end else begin
            st = 2'b01;
        end
    endtask

    // Issue one command from an idle controller and check its full timeline
    task automatic do_cmd(input logic [15:0] op, input logic [15:0] d, input int ack_delay,
                          input logic [15:0] ld, input int hold);
        logic [1:0]  st;
        logic [15:0] rd;
        logic [3:0]  sm;
        bit is_lk, acked;
        is_lk = (op[15:12] == 4'h1) && (int'(op[11:8]) < NUM_CH);
        acked = (ack_delay >= 0) && (ack_delay <= TIMEOUT);
        model_exec(op, d, acked, ld, st, rd, sm);
        bus.rsp_ready     = (hold == 0);
        bus.op_code_bus   = op;
        bus.user_data_bus = d;
        bus.cmd_valid     = 1'b1;
        check("cmd_ready_idle", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        tick();
        tick();
        check("no_rsp_at_T2", bus.rsp_valid, 0);
        tick();
        if (is_lk) begin
            check("lut_req_at_T3", bus.lut_req, 1);
            check("lut_addr", bus.lut_addr, op[7:0]);
            check("no_rsp_in_lookup", bus.rsp_valid, 0);
            if (acked) begin
                repeat (ack_delay) tick();
                bus.lut_ack  = 1'b1;
                bus.lut_data = ld;
                tick();
                bus.lut_ack  = 1'b0;
            end else begin
                repeat (TIMEOUT) tick();
                check("no_rsp_before_timeout", bus.rsp_valid, 0);
                check("lut_req_before_timeout", bus.lut_req, 1);
                tick();
            end
            check("lut_req_dropped", bus.lut_req, 0);
        end
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_status", bus.rsp_status, st);
        if (st != 2'b10) check("rsp_data", bus.rsp_data, rd);
        check("sens_start", bus.sens_start, sm);
        check("sens_cfg", bus.sens_cfg, flat_cfg());
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rsp_valid_held", bus.rsp_valid, 1);
            check("rsp_status_held", bus.rsp_status, st);
            if (st != 2'b10) check("rsp_data_held", bus.rsp_data, rd);
            check("sens_start_one_cycle", bus.sens_start, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("rsp_valid_cleared", bus.rsp_valid, 0);
        check("sens_start_cleared", bus.sens_start, 0);
        check("busy_cleared", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  st;
        logic [15:0] rd;
        logic [3:0]  sm;
        logic [15:0] bp_op [5];
        logic [15:0] bp_d  [5];
        logic [1:0]  q_st [$];
        logic [15:0] q_rd [$];
        int acc, got, w;
        bit ok;

        bus.op_code_bus = '0; bus.user_data_bus = '0; bus.cmd_valid = 1'b0;
        bus.lut_ack = 1'b0; bus.lut_data = '0; bus.rsp_ready = 1'b1;
        reset_n = 1'b1;
        model_reset();

        // Reset state
        tick(); tick();
        check("reset_sens_cfg", bus.sens_cfg, flat_cfg());
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_cmd_ready", bus.cmd_ready, 0);
        check("reset_lut_req", bus.lut_req, 0);
        check("reset_sens_start", bus.sens_start, 0);
        check("reset_busy", bus.busy, 0);
        reset_n = 1'b0;
        check("cmd_ready_before_edge", bus.cmd_ready, 0);
        tick();
        check("cmd_ready_after_release", bus.cmd_ready, 1);

        // Directed commands
        do_cmd(16'h2100, 16'hBEEF, -1, 16'h0, 0);
        do_cmd(16'h2355, 16'h0F0F, -1, 16'h0, 1);
        do_cmd(16'h1235, 16'h0000, 5, 16'h1234, 0);
        do_cmd(16'h1235, 16'h0000, -1, 16'h0, 0);
        do_cmd(16'h10AA, 16'h0000, int'(TIMEOUT), 16'hA5A5, 2);
        do_cmd(16'h4100, 16'h0000, -1, 16'h0, 0);
        do_cmd(16'h2700, 16'h7777, -1, 16'h0, 0);
        do_cmd(16'h9000, 16'h1111, -1, 16'h0, 0);
        do_cmd(16'h3100, 16'h0000, -1, 16'h0, 0);
        do_cmd(16'h1500, 16'h0000, 3, 16'h5555, 0);
        do_cmd(16'h3F00, 16'h0000, -1, 16'h0, 0);
        do_cmd(16'h3900, 16'h0000, -1, 16'h0, 0);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            logic [3:0] opc, ch;
            int sel, dly;
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      opc = 4'h1;
            else if (sel < 5) opc = 4'h2;
            else if (sel < 6) opc = 4'h3;
            else if (sel < 8) opc = 4'h4;
            else              opc = 4'($urandom_range(5, 16));
            if ($urandom_range(0, 4) == 0) ch = 4'($urandom_range(0, 15));
            else                           ch = 4'($urandom_range(0, NUM_CH - 1));
            dly = int'($urandom_range(0, 12));
            do_cmd({opc, ch, 8'($urandom)}, 16'($urandom), dly, 16'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // Backpressure: one response held, then fill the FIFO
        bus.rsp_ready = 1'b0;
        model_exec(16'h2000, 16'h1111, 1'b0, 16'h0, st, rd, sm);
        q_st.push_back(st); q_rd.push_back(rd);
        bus.op_code_bus = 16'h2000; bus.user_data_bus = 16'h1111; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        w = 0;
        while (!bus.rsp_valid && w < 10) begin tick(); w++; end
        check("bp_first_rsp", bus.rsp_valid, 1);
        bp_op[0] = 16'h2000; bp_d[0] = 16'hC0DE;
        bp_op[1] = 16'h4000; bp_d[1] = 16'h0000;
        bp_op[2] = 16'h2300; bp_d[2] = 16'hFACE;
        bp_op[3] = 16'h9000; bp_d[3] = 16'h0000;
        bp_op[4] = 16'h3300; bp_d[4] = 16'h0000;
        acc = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.op_code_bus = bp_op[acc]; bus.user_data_bus = bp_d[acc]; bus.cmd_valid = 1'b1;
            ok = bus.cmd_ready;
            tick();
            if (ok && acc < 4) begin
                model_exec(bp_op[acc], bp_d[acc], 1'b0, 16'h0, st, rd, sm);
                q_st.push_back(st); q_rd.push_back(rd);
                acc++;
            end else if (ok) begin
                acc++;
            end
        end
        check("bp_accepted_count", acc, 4);
        check("bp_cmd_ready_low", bus.cmd_ready, 0);
        check("bp_rsp_held", bus.rsp_valid, 1);
        check("bp_rsp_data_held", bus.rsp_data, 16'h1111);

        bus.rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            if (acc < 5) begin
                bus.op_code_bus = bp_op[acc]; bus.user_data_bus = bp_d[acc]; bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            ok = bus.cmd_ready && (acc < 5);
            if (bus.rsp_valid) begin
                if (q_st.size() == 0) begin
                    check("bp_extra_rsp", bus.rsp_valid, 0);
                end else begin
                    st = q_st.pop_front();
                    rd = q_rd.pop_front();
                    check("bp_rsp_status", bus.rsp_status, st);
                    check("bp_rsp_data", bus.rsp_data, rd);
                end
                got++;
            end
            tick();
            if (ok) begin
                model_exec(bp_op[acc], bp_d[acc], 1'b0, 16'h0, st, rd, sm);
                q_st.push_back(st); q_rd.push_back(rd);
                acc++;
            end
        end
        bus.cmd_valid = 1'b0;
        check("bp_all_rsp", got, 6);
        tick(); tick(); tick();
        check("bp_no_dup_rsp", bus.rsp_valid, 0);
        check("bp_sens_cfg", bus.sens_cfg, flat_cfg());

        // Reset during a lookup, with a second command still queued
        bus.op_code_bus = 16'h1235; bus.user_data_bus = 16'h0; bus.cmd_valid = 1'b1;
        tick();
        bus.op_code_bus = 16'h2100; bus.user_data_bus = 16'h4242;
        tick();
        bus.cmd_valid = 1'b0;
        tick(); tick();
        check("mid_lookup_lut_req", bus.lut_req, 1);
        reset_n = 1'b1;
        #1;
        model_reset();
        check("reset_drops_lut_req", bus.lut_req, 0);
        check("reset_busy_clear", bus.busy, 0);
        check("reset_cfg_default", bus.sens_cfg, flat_cfg());
        tick();
        reset_n = 1'b0;
        tick();
        check("cmd_ready_after_rereset", bus.cmd_ready, 1);
        repeat (4) tick();
        check("fifo_empty_after_reset", bus.busy, 0);
        check("no_rsp_after_reset", bus.rsp_valid, 0);
        check("no_lut_req_after_reset", bus.lut_req, 0);
        do_cmd(16'h2200, 16'h600D, -1, 16'h0, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/cmd_decode_ctrl.md
# cmd_decode_ctrl

Parametrised command decoder and sensor-configuration controller for the RFID tag digital core. It accepts 16-bit opcode words plus user data from the command parser and buffers them in a small FIFO. It executes each command against per-channel sensor configuration registers, including an optional lookup-table fetch, and returns one status/response per command over a valid/ready handshake. It sits between the command parser and the sensor front-end / configuration LUT.

## Interface
- DATA_W, 16, width of user data, LUT data, configuration and response words
- NUM_CH, 4, number of sensor channels (1..15)
- DEPTH, 4, command FIFO depth (power of 2, ≥2)
- TIMEOUT, 255, maximum cycles to wait for lut_ack
- DEFAULT_CFG, 16'h0000, reset/default configuration value per channel (DATA_W bits)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, **active-high** (asserted = 1) despite the suffix
- op_code_bus  in  16  [15:12] opcode, [11:8] channel, [7:0] LUT address/argument
- user_data_bus  in  DATA_W  data accompanying the opcode
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept
- lut_req  out  1  lookup request, held until ack or timeout
- lut_addr  out  8  lookup address
- lut_ack  in  1  lookup data valid, one cycle
- lut_data  in  DATA_W  lookup result
- sens_cfg  out  NUM_CH*DATA_W  configuration registers, channel c at [c*DATA_W +: DATA_W]
- sens_start  out  NUM_CH  one-cycle pulse per channel whose configuration was written
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  response payload
- rsp_status  out  2  00 ok, 01 bad opcode, 10 bad channel, 11 LUT timeout
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Reset: FIFO empty, FSM IDLE, every sens_cfg channel = DEFAULT_CFG, all other outputs 0. cmd_ready rises on the first clock after reset release. Reset mid-lookup drops lut_req immediately.
- FIFO: stores {op_code_bus, user_data_bus}. Push on cmd_valid && cmd_ready. cmd_ready = (count < DEPTH), registered. When full, no push occurs even if a pop happens in the same cycle. Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, LOOKUP, RESP.
  - IDLE: if FIFO is non-empty, pop the head into a command register and go to EXEC.
  - EXEC:
    - Opcode 4'h1 CONFIG_LOOKUP: if ch < NUM_CH, go to LOOKUP. Otherwise status 10 and go to RESP.
    - Opcode 4'h2 CONFIG_SENSOR: if ch < NUM_CH, sens_cfg[ch] ← user data, pulse sens_start[ch], rsp_data = user data, status 00. Otherwise status 10.
    - Opcode 4'h3 DEFAULT_SENSOR: if ch < NUM_CH, sens_cfg[ch] ← DEFAULT_CFG and pulse that channel. If ch = 4'hF, all channels ← DEFAULT_CFG and all sens_start bits pulse. Otherwise status 10. rsp_data = DEFAULT_CFG.
    - Opcode 4'h4 READ_CONFIG: rsp_data = sens_cfg[ch], no write. Status 10 if ch is out of range.
    - Any other opcode: status 01, rsp_data = 0, no side effects.
    - All non-lookup paths go to RESP.
  - LOOKUP: lut_req = 1, lut_addr = arg. A 9-bit wait counter starts at 0.
    - On lut_ack: sens_cfg[ch] ← lut_data, pulse sens_start[ch], rsp_data = lut_data, status 00.
    - If the counter reaches TIMEOUT before ack: status 11, rsp_data = 0, configuration unchanged.
    - Either outcome goes to RESP. An ack arriving in the same cycle as the timeout wins.
  - RESP: rsp_valid = 1, with data and status stable until rsp_ready. On the rsp_valid && rsp_ready cycle, return to IDLE.
- Any bad-channel or bad-opcode response leaves sens_cfg and sens_start untouched.

## Timing
- All outputs registered.
- Accepting edge T with FIFO empty and FSM IDLE:
  - FIFO non-empty after T+1.
  - EXEC at T+2.
  - sens_start pulse and rsp_valid high at T+3.
- Lookup path: lut_req rises at T+3. An ack in cycle A gives rsp_valid and sens_start at A+1.
- Throughput: with rsp_ready tied high, one non-lookup command per 3 cycles.
- sens_start is exactly one cycle wide and coincides with the first rsp_valid cycle.
- lut_req deasserts on the cycle after ack or timeout.
- A timeout response occurs TIMEOUT+1 cycles after lut_req rises.

## Test plan
- Reset: apply reset_n = 1 -> all sens_cfg = DEFAULT_CFG, rsp_valid = 0, cmd_ready = 0. Release -> cmd_ready = 1 after one edge.
- Config write: op 16'h2100, data 16'hBEEF -> sens_cfg ch1 = BEEF, sens_start = 4'b0010 at T+3, rsp_data BEEF, status 00.
- Lookup: op 16'h1235, lut_ack with data 16'h1234 after 5 cycles -> lut_addr 8'h35, ch2 = 1234, status 00. Repeat with no ack -> status 11 after 256 cycles, ch2 unchanged.
- Errors: op 16'h2700 with NUM_CH = 4 -> status 10, no sens_start. Op 16'h9000 -> status 01. Op 16'h3F00 -> all channels default, sens_start = 4'b1111.
- Backpressure: hold rsp_ready = 0 and push 5 commands -> cmd_ready falls after 4 are accepted (DEPTH = 4). Release rsp_ready -> responses emerge in order with no loss or duplication.
- Reset asserted during LOOKUP -> lut_req low immediately, FIFO empty, FSM IDLE.
